// File: rtl/ps2_pkg.sv
// Shared constants, state encoding and parity helper for the PS/2 keyboard receiver.
// Imported by the interface, the buffer FIFO and the receiver top.
package ps2_pkg;

  localparam int FRAME_BITS = 11;
  localparam int CODE_W     = 8;
  localparam int ENTRY_W    = 10;
  // Everything after the start bit: 8 data bits, parity, stop.
  localparam int SHIFT_BITS = FRAME_BITS - 1;

  localparam logic [CODE_W-1:0] PREFIX_EXT = 8'hE0;
  localparam logic [CODE_W-1:0] PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } ps2_state_t;

  function automatic logic frameParityOk(input logic [CODE_W:0] data_parity);
    return ^data_parity;
  endfunction

endpackage

// File: rtl/ps2_keyboard_receiver_if.sv
// Consumer-side bus of the PS/2 receiver: FIFO head, ready/received handshake and error flags.
// The receiver drives it through the master modport; the CPU/peripheral side uses slave.
interface ps2_keyboard_receiver_if
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) ();

  localparam int COUNT_W = $clog2(FIFO_DEPTH + 1);

  logic [ENTRY_W-1:0] oKey_Data_Out;
  logic               oData_Ready;
  logic               iData_Received;
  logic [COUNT_W-1:0] oFifo_Count;
  logic               oParity_Error;
  logic               oFrame_Error;
  logic               oOverflow;
  logic               iClear_Errors;

  modport master (
    output oKey_Data_Out,
    output oData_Ready,
    output oFifo_Count,
    output oParity_Error,
    output oFrame_Error,
    output oOverflow,
    input  iData_Received,
    input  iClear_Errors
  );

  modport slave (
    input  oKey_Data_Out,
    input  oData_Ready,
    input  oFifo_Count,
    input  oParity_Error,
    input  oFrame_Error,
    input  oOverflow,
    output iData_Received,
    output iClear_Errors
  );

endinterface

// File: rtl/ps2_keyboard_receiver_sync_fifo.sv
// Show-ahead synchronous FIFO buffering decoded scan-code entries.
// A push into a full FIFO is only accepted when a pop happens in the same cycle.
module sync_fifo
  import ps2_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = 8
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int COUNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == COUNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  // Storage is left unreset; the pointers alone decide which entries are live.
  always_ff @(posedge Clock) begin
    if (!Reset && do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 keyboard receiver: pin synchronisers, clock deglitch filter, frame FSM,
// E0/F0 prefix decode and a FIFO of {break, extended, code} entries.
module ps2_keyboard_receiver
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_LEN    = 4,
  parameter int TIMEOUT_CYC   = 5000,
  parameter int DECODE_PREFIX = 1
) (
  input  logic Clock,
  input  logic Reset,
  input  logic iKey_Clock,
  input  logic iKey_Data_In,
  ps2_keyboard_receiver_if.master bus
);

  localparam int FILT_W  = $clog2(FILTER_LEN + 1);
  localparam int TIME_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int CNT_W   = $clog2(SHIFT_BITS);
  localparam int COUNT_W = $clog2(FIFO_DEPTH + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_synced;
  logic                   data_synced;
  logic                   kbd_clk_filt;
  logic                   filt_prev;
  logic [FILT_W-1:0]      filt_cnt;
  logic                   kbd_edge;

  ps2_state_t            state, state_next;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_next;
  logic [SHIFT_BITS-1:0] shift_reg, shift_next;
  logic [TIME_W-1:0]     timer, timer_next;
  logic                  ext_flag, ext_next;
  logic                  brk_flag, brk_next;
  logic                  set_frame;
  logic                  set_parity;
  logic                  push_code;

  logic [CODE_W-1:0]     code;
  logic                  stop_bit;
  logic                  parity_ok;

  logic [ENTRY_W-1:0]    fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [COUNT_W-1:0]    fifo_count;
  logic                  pop_ok;
  logic                  parity_err;
  logic                  frame_err;
  logic                  overflow;

  // Both pins reset to the idle-high level so leaving reset never looks like a fall.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], iKey_Clock};
      data_sync <= {data_sync[SYNC_STAGES-2:0], iKey_Data_In};
    end
  end

  assign clk_synced  = clk_sync[SYNC_STAGES-1];
  assign data_synced = data_sync[SYNC_STAGES-1];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      kbd_clk_filt <= 1'b1;
      filt_prev    <= 1'b1;
      filt_cnt     <= '0;
    end else begin
      filt_prev <= kbd_clk_filt;
      if (clk_synced == kbd_clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_W'(FILTER_LEN - 1)) begin
        kbd_clk_filt <= clk_synced;
        filt_cnt     <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign kbd_edge = filt_prev & ~kbd_clk_filt;

  assign code      = shift_reg[CODE_W-1:0];
  assign stop_bit  = shift_reg[SHIFT_BITS-1];
  assign parity_ok = frameParityOk(shift_reg[CODE_W:0]);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      timer     <= '0;
      ext_flag  <= 1'b0;
      brk_flag  <= 1'b0;
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_cnt_next;
      shift_reg <= shift_next;
      timer     <= timer_next;
      ext_flag  <= ext_next;
      brk_flag  <= brk_next;
    end
  end

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shift_next   = shift_reg;
    timer_next   = timer;
    ext_next     = ext_flag;
    brk_next     = brk_flag;
    set_frame    = 1'b0;
    set_parity   = 1'b0;
    push_code    = 1'b0;

    case (state)
      IDLE: begin
        if (kbd_edge) begin
          if (!data_synced) begin
            state_next   = SHIFT;
            bit_cnt_next = '0;
            timer_next   = '0;
          end else begin
            set_frame = 1'b1;
          end
        end
      end

      SHIFT: begin
        if (kbd_edge) begin
          shift_next = {data_synced, shift_reg[SHIFT_BITS-1:1]};
          timer_next = '0;
          if (bit_cnt == CNT_W'(SHIFT_BITS - 1)) begin
            state_next = CHECK;
          end else begin
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end else if (timer == TIME_W'(TIMEOUT_CYC - 1)) begin
          // A silent keyboard mid-frame loses the frame and any pending prefix.
          set_frame  = 1'b1;
          state_next = IDLE;
          ext_next   = 1'b0;
          brk_next   = 1'b0;
        end else begin
          timer_next = timer + 1'b1;
        end
      end

      CHECK: begin
        state_next = IDLE;
        if (!stop_bit) begin
          set_frame = 1'b1;
          ext_next  = 1'b0;
          brk_next  = 1'b0;
        end else if (!parity_ok) begin
          set_parity = 1'b1;
          ext_next   = 1'b0;
          brk_next   = 1'b0;
        end else if ((DECODE_PREFIX != 0) && (code == PREFIX_EXT)) begin
          ext_next = 1'b1;
        end else if ((DECODE_PREFIX != 0) && (code == PREFIX_BRK)) begin
          brk_next = 1'b1;
        end else begin
          push_code = 1'b1;
          ext_next  = 1'b0;
          brk_next  = 1'b0;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clock   (Clock),
    .Reset   (Reset),
    .push    (push_code),
    .pop     (bus.iData_Received),
    .wr_data ({brk_flag, ext_flag, code}),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign pop_ok = bus.iData_Received & ~fifo_empty;

  // A same-cycle set beats the clear request so no error event is ever lost.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      parity_err <= set_parity | (parity_err & ~bus.iClear_Errors);
      frame_err  <= set_frame | (frame_err & ~bus.iClear_Errors);
      overflow   <= (push_code & fifo_full & ~pop_ok) | (overflow & ~bus.iClear_Errors);
    end
  end

  assign bus.oKey_Data_Out = fifo_empty ? '0 : fifo_head;
  assign bus.oData_Ready   = ~fifo_empty;
  assign bus.oFifo_Count   = fifo_count;
  assign bus.oParity_Error = parity_err;
  assign bus.oFrame_Error  = frame_err;
  assign bus.oOverflow     = overflow;

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Scoreboard bench: a prefix-decoding receiver (FIFO_DEPTH=4) and a raw receiver
// (DECODE_PREFIX=0, always popping) listen to the same directed PS/2 frames.
module tb_ps2_keyboard_receiver;
  import ps2_pkg::*;

  localparam int DEPTH   = 4;
  localparam int SYNC    = 2;
  localparam int FILT    = 4;
  localparam int TIMEOUT = 400;
  localparam int HALF    = 20;
  localparam int GAP     = 20;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic kbd_clk = 1'b1;
  logic kbd_data = 1'b1;
  logic pop_req = 1'b0;
  logic clear_req = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [ENTRY_W-1:0] exp_q[$];
  logic [ENTRY_W-1:0] raw_q[$];

  ps2_keyboard_receiver_if #(.FIFO_DEPTH(DEPTH)) main_if ();
  ps2_keyboard_receiver_if #(.FIFO_DEPTH(DEPTH)) raw_if ();

  assign main_if.iData_Received = pop_req;
  assign main_if.iClear_Errors  = clear_req;
  assign raw_if.iData_Received  = 1'b1;
  assign raw_if.iClear_Errors   = clear_req;

  ps2_keyboard_receiver #(
    .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .FILTER_LEN(FILT),
    .TIMEOUT_CYC(TIMEOUT), .DECODE_PREFIX(1)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iKey_Clock(kbd_clk), .iKey_Data_In(kbd_data), .bus(main_if)
  );

  ps2_keyboard_receiver #(
    .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .FILTER_LEN(FILT),
    .TIMEOUT_CYC(TIMEOUT), .DECODE_PREFIX(0)
  ) dut_raw (
    .Clock(Clock), .Reset(Reset), .iKey_Clock(kbd_clk), .iKey_Data_In(kbd_data), .bus(raw_if)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main receiver: every accepted pop must match the oldest expected entry.
  always @(negedge Clock) begin
    if (!Reset && main_if.oData_Ready && main_if.iData_Received) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL main_pop: got 0x%03h with nothing expected", main_if.oKey_Data_Out);
      end else begin
        logic [ENTRY_W-1:0] want;
        want = exp_q.pop_front();
        if (main_if.oKey_Data_Out !== want) begin
          errors++;
          $display("[TB] FAIL main_pop: got 0x%03h expected 0x%03h", main_if.oKey_Data_Out, want);
        end
      end
    end
  end

  // Raw receiver pops every cycle it is ready.
  always @(negedge Clock) begin
    if (!Reset && raw_if.oData_Ready) begin
      checks++;
      if (raw_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL raw_pop: got 0x%03h with nothing expected", raw_if.oKey_Data_Out);
      end else begin
        logic [ENTRY_W-1:0] want;
        want = raw_q.pop_front();
        if (raw_if.oKey_Data_Out !== want) begin
          errors++;
          $display("[TB] FAIL raw_pop: got 0x%03h expected 0x%03h", raw_if.oKey_Data_Out, want);
        end
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // With pop_on_check, iData_Received is pulsed in the CHECK cycle of this bit's edge.
  task automatic driveBit(input logic b, input bit pop_on_check);
    kbd_data = b;
    waitCycles(HALF);
    kbd_clk = 1'b0;
    if (pop_on_check) begin
      waitCycles(SYNC + FILT + 1);
      pop_req = 1'b1;
      waitCycles(1);
      pop_req = 1'b0;
      waitCycles(HALF - SYNC - FILT - 2);
    end else begin
      waitCycles(HALF);
    end
    kbd_clk = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] code, input bit bad_parity,
                               input bit store_main, input logic [ENTRY_W-1:0] main_entry,
                               input bit store_raw, input bit pop_on_check);
    logic [FRAME_BITS-1:0] frame;
    logic par;
    if (store_main) exp_q.push_back(main_entry);
    if (store_raw) raw_q.push_back({2'b00, code});
    par = ~(^code) ^ bad_parity;
    frame = {1'b1, par, code, 1'b0};
    for (int i = 0; i < FRAME_BITS; i++) driveBit(frame[i], pop_on_check && (i == FRAME_BITS - 1));
    waitCycles(GAP);
  endtask

  task automatic popOne();
    pop_req = 1'b1;
    waitCycles(1);
    pop_req = 1'b0;
    waitCycles(1);
  endtask

  task automatic pulseClear();
    clear_req = 1'b1;
    waitCycles(1);
    clear_req = 1'b0;
    waitCycles(1);
  endtask

  task automatic checkAllZero(input string tag);
    @(negedge Clock);
    checkOutput({tag, "_data"}, main_if.oKey_Data_Out, 0);
    checkOutput({tag, "_ready"}, main_if.oData_Ready, 0);
    checkOutput({tag, "_count"}, main_if.oFifo_Count, 0);
    checkOutput({tag, "_parity"}, main_if.oParity_Error, 0);
    checkOutput({tag, "_frame"}, main_if.oFrame_Error, 0);
    checkOutput({tag, "_overflow"}, main_if.oOverflow, 0);
    waitCycles(1);
  endtask

  initial begin
    $display("[TB] start");
    waitCycles(4);
    Reset = 1'b0;
    waitCycles(2);
    checkAllZero("reset");

    // Single make code.
    applyStimulus(8'h1C, 0, 1, 10'h01C, 1, 0);
    @(negedge Clock);
    checkOutput("t1_ready", main_if.oData_Ready, 1);
    checkOutput("t1_data", main_if.oKey_Data_Out, 10'h01C);
    checkOutput("t1_count", main_if.oFifo_Count, 1);
    popOne();
    @(negedge Clock);
    checkOutput("t1_count_after_pop", main_if.oFifo_Count, 0);

    // Extended break sequence collapses to one decoded entry.
    applyStimulus(8'hE0, 0, 0, 10'h000, 1, 0);
    applyStimulus(8'hF0, 0, 0, 10'h000, 1, 0);
    applyStimulus(8'h75, 0, 1, 10'h375, 1, 0);
    @(negedge Clock);
    checkOutput("t2_count", main_if.oFifo_Count, 1);
    checkOutput("t2_data", main_if.oKey_Data_Out, 10'h375);
    popOne();

    // Bad parity is dropped and flagged until cleared.
    applyStimulus(8'h1C, 1, 0, 10'h000, 0, 0);
    @(negedge Clock);
    checkOutput("t3_parity_set", main_if.oParity_Error, 1);
    checkOutput("t3_no_push", main_if.oFifo_Count, 0);
    checkOutput("t3_frame_clear", main_if.oFrame_Error, 0);
    pulseClear();
    @(negedge Clock);
    checkOutput("t3_parity_cleared", main_if.oParity_Error, 0);
    applyStimulus(8'h1C, 0, 1, 10'h01C, 1, 0);
    @(negedge Clock);
    checkOutput("t3_next_count", main_if.oFifo_Count, 1);
    popOne();

    // Overflow: fifth code dropped.
    applyStimulus(8'h1C, 0, 1, 10'h01C, 1, 0);
    applyStimulus(8'h32, 0, 1, 10'h032, 1, 0);
    applyStimulus(8'h21, 0, 1, 10'h021, 1, 0);
    applyStimulus(8'h23, 0, 1, 10'h023, 1, 0);
    applyStimulus(8'h24, 0, 0, 10'h000, 1, 0);
    @(negedge Clock);
    checkOutput("t4_count_full", main_if.oFifo_Count, 4);
    checkOutput("t4_overflow", main_if.oOverflow, 1);
    pulseClear();
    @(negedge Clock);
    checkOutput("t4_overflow_cleared", main_if.oOverflow, 0);
    for (int i = 0; i < 4; i++) popOne();
    @(negedge Clock);
    checkOutput("t4_drained", main_if.oFifo_Count, 0);

    // Push and pop together while full.
    applyStimulus(8'h1C, 0, 1, 10'h01C, 1, 0);
    applyStimulus(8'h32, 0, 1, 10'h032, 1, 0);
    applyStimulus(8'h21, 0, 1, 10'h021, 1, 0);
    applyStimulus(8'h23, 0, 1, 10'h023, 1, 0);
    applyStimulus(8'h24, 0, 1, 10'h024, 1, 1);
    @(negedge Clock);
    checkOutput("t4b_count", main_if.oFifo_Count, 4);
    checkOutput("t4b_no_overflow", main_if.oOverflow, 0);
    for (int i = 0; i < 4; i++) popOne();

    // Truncated frame times out.
    driveBit(1'b0, 0);
    driveBit(1'b0, 0);
    driveBit(1'b0, 0);
    driveBit(1'b1, 0);
    driveBit(1'b1, 0);
    kbd_data = 1'b1;
    waitCycles(TIMEOUT - HALF - 40);
    @(negedge Clock);
    checkOutput("t5_no_early_timeout", main_if.oFrame_Error, 0);
    waitCycles(100);
    @(negedge Clock);
    checkOutput("t5_timeout", main_if.oFrame_Error, 1);
    checkOutput("t5_no_push", main_if.oFifo_Count, 0);
    pulseClear();
    applyStimulus(8'h1C, 0, 1, 10'h01C, 1, 0);
    @(negedge Clock);
    checkOutput("t5_recovered", main_if.oFifo_Count, 1);
    popOne();

    // Short glitch on an idle bus must not look like a start edge.
    kbd_data = 1'b1;
    kbd_clk = 1'b0;
    waitCycles(2);
    kbd_clk = 1'b1;
    waitCycles(40);
    @(negedge Clock);
    checkOutput("t6_glitch_ignored", main_if.oFrame_Error, 0);

    // Reset in the middle of a frame with buffered data and a pending error.
    applyStimulus(8'h1C, 0, 1, 10'h01C, 1, 0);
    applyStimulus(8'h32, 1, 0, 10'h000, 0, 0);
    @(negedge Clock);
    checkOutput("t6_pre_reset_parity", main_if.oParity_Error, 1);
    driveBit(1'b0, 0);
    driveBit(1'b1, 0);
    driveBit(1'b0, 0);
    driveBit(1'b0, 0);
    kbd_data = 1'b1;
    waitCycles(5);
    Reset = 1'b1;
    exp_q.delete();
    waitCycles(3);
    Reset = 1'b0;
    waitCycles(2);
    checkAllZero("t6_reset");
    applyStimulus(8'h21, 0, 1, 10'h021, 1, 0);
    @(negedge Clock);
    checkOutput("t6_after_reset_count", main_if.oFifo_Count, 1);
    popOne();

    waitCycles(5);
    checkOutput("main_queue_empty", exp_q.size(), 0);
    checkOutput("raw_queue_empty", raw_q.size(), 0);
    checkOutput("raw_count_zero", raw_if.oFifo_Count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
